// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Issuing side of a small ALU operand/opcode interface. Commands {a,b,op}
// enter through a valid/ready port into a DEPTH-entry FIFO. They are issued
// one at a time on registered alu_* outputs to an external combinational ALU.
// The result is sampled after one settle cycle and is returned on a
// valid/ready response port. A counter tracks completed handoffs.
module alu_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   // command channel
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_op,
   // ALU drive / sample
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [1:0]       rsp_op,
   output logic [CNT_W-1:0] ops_done
);

   // FIFO geometry: pointers wrap naturally because DEPTH is a power of two
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 2 * WIDTH + 2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // FIFO state
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   // sequencer state
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [1:0]       rsp_op_q, rsp_op_d;
   logic [CNT_W-1:0] ops_done_q, ops_done_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [EW-1:0]    head;

   // Ready depends only on registered occupancy. It is never opened by a
   // pop on the same edge, so cmd_ready has no combinational path from
   // rsp_ready.
   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem_q[rd_ptr_q];

   // Issue/response FSM: decides when to pop, load the ALU operands and
   // sample or release the response.
   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      ops_done_d   = ops_done_q;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop                           = 1'b1;
               {alu_a_d, alu_b_d, alu_op_d}  = head;
               state_d                       = ST_DRIVE;
            end
         end

         // operands have been stable for a full cycle; sample the ALU
         ST_DRIVE: begin
            rsp_result_d = alu_result;
            rsp_op_d     = alu_op_q;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
         end

         ST_RESP: begin
            if (rsp_ready) begin
               ops_done_d  = ops_done_q + CNT_W'(1);
               rsp_valid_d = 1'b0;
               if (!empty) begin
                  pop                           = 1'b1;
                  {alu_a_d, alu_b_d, alu_op_d}  = head;
                  state_d                       = ST_DRIVE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy update from the push/pop pair
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage: payload only, no reset needed since occupancy guards reads
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
      end
   end

   // FIFO control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FSM, ALU drive, response and counter registers; all visibly reset to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_op     = rsp_op_q;
   assign ops_done   = ops_done_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Issuing end of the 4-bit ALU operand/opcode interface.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives operands and opcode one command at a time into an external combinational ALU, samples its result after a settle cycle, and returns the result over a valid/ready response channel.
- Sits between the control/test driver and the ALU datapath; the ALU itself is unchanged.

Parameters:
- WIDTH, 4, operand and result width in bits.
- DEPTH, 4, command FIFO entries (power of two, at least 2).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals not-full.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_op  input  2  opcode: 00 add, 10 sub, 01 or, 11 xor.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_opcode  output  2  registered opcode to ALU.
- alu_result  input  WIDTH  combinational result from ALU.
- rsp_valid  output  1  response held valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  sampled ALU result.
- rsp_op  output  2  opcode of the returned result.
- ops_done  output  CNT_W  count of responses handed off; wraps modulo 2^CNT_W.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - FIFO emptied; FSM goes to IDLE.
  - alu_a, alu_b, alu_opcode, rsp_result, rsp_op and ops_done are all 0; rsp_valid is 0.
  - cmd_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards buffered and in-flight commands; no response is produced for them.
- **Command push:** an entry {a,b,op} is written on an edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready = !full, from registered occupancy only.
  - When full, no push occurs even if a pop happens the same edge.
  - cmd_valid while cmd_ready=0 is ignored; the source must hold the command.
- **FSM IDLE:**
  - If the FIFO is non-empty: pop the head into alu_a/alu_b/alu_opcode, go to DRIVE.
  - Else stay in IDLE.
  - A command pushed on edge t is not visible to IDLE until edge t+1.
- **FSM DRIVE** (exactly one cycle, the ALU settle cycle): at the edge, capture rsp_result <= alu_result and rsp_op <= alu_opcode, set rsp_valid=1, go to RESP.
- **FSM RESP:** rsp_valid, rsp_result and rsp_op are held stable until rsp_ready=1. On the handshake edge:
  - ops_done increments; rsp_valid goes to 0 unless reloaded.
  - If the FIFO is non-empty, pop the next head into the alu_* registers and go straight to DRIVE.
  - Else go to IDLE.
- **alu_* outputs** keep their last issued values while idle; they change only on a pop.
- **Latency:** command accepted on edge 0 with an empty, idle block gives rsp_valid=1 after edge 2.
- **Throughput:** one response per 2 cycles with rsp_ready held at 1.
- **Capacity:** up to DEPTH+1 commands accepted before stall (DEPTH buffered plus one in flight).
- **Arithmetic:** performed only by the external ALU and truncated to WIDTH. The sequencer never alters or checks the result.
- **FIFO pointers** wrap modulo DEPTH. Occupancy counts 0..DEPTH; full is DEPTH, empty is 0.
- **Simultaneous push and pop** (not full) leaves occupancy unchanged and preserves order.

Test Plan:
- Reset, then add A=7, B=9, op=00 with rsp_ready=1:
  - alu_a=7, alu_b=9 after edge 1.
  - rsp_valid=1, rsp_result=0 (wrap), rsp_op=00 after edge 2.
  - ops_done=1 after edge 3.
- Back-to-back commands with rsp_ready=1, all results in order, spaced 2 cycles apart, ops_done=4 at end:
  - sub 3-5 gives 4'hE;
  - or A|5 gives 4'hF;
  - xor C^A gives 4'h6;
  - sub 9-2 gives 4'h7.
- Backpressure with rsp_ready=0, cmd_valid held with 6 commands:
  - cmd_ready drops after the 5th accept; the 6th stalls.
  - The first response is held stable for 10 cycles.
  - Then rsp_ready=1 drains all 6 in order; ops_done=6.
- Reset asserted while in RESP with 3 entries buffered:
  - Next cycle: rsp_valid=0, cmd_ready=1, ops_done=0, alu_*=0.
  - No stale response appears over the following 10 cycles.
- Counter wrap with CNT_W=8: 257 completed ops gives ops_done=1.
- Idle stability: after the last response, alu_a/alu_b/alu_opcode keep their last values and rsp_valid stays 0 with cmd_valid=0.
